// File: rtl/mtm_alu_pkg.sv
// Shared constants, FSM encoding and byte helpers for the mtm_alu serial output path.
package mtm_alu_pkg;

  localparam int FRAME_LEN   = 11;
  localparam int DATA_FRAMES = 4;

  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CTL  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Error CTL byte: marker bit, the six flags, then parity over marker and flags.
  function automatic logic [7:0] ctl_err_byte(input logic [5:0] err_flags);
    return {1'b1, err_flags, ^{1'b1, err_flags}};
  endfunction

endpackage

// File: rtl/mtm_alu_frame_tx.sv
// Single 11-bit frame shifter: start(0), type, 8 data bits MSB first, stop(1).
module mtm_alu_frame_tx
  import mtm_alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_type,
  input  logic [7:0] i_byte,
  output logic       o_sout,
  output logic       o_frame_done
);

  localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      BIT_LAST  = 4'(FRAME_LEN - 1);

  logic [FRAME_LEN-1:0] r_shift;
  logic [3:0]           r_bit_cnt;
  logic [BW-1:0]        r_baud_cnt;
  logic                 r_active;
  logic                 w_bit_end;

  assign w_bit_end    = r_active && (r_baud_cnt == BAUD_LAST);
  // Asserted during the final cycle of the stop bit so a new load can follow seamlessly.
  assign o_frame_done = w_bit_end && (r_bit_cnt == BIT_LAST);
  assign o_sout       = r_active ? r_shift[FRAME_LEN-1] : 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift    <= '1;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_active   <= 1'b0;
    end else if (i_load) begin
      r_shift    <= {1'b0, i_type, i_byte, 1'b1};
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_active   <= 1'b1;
    end else if (o_frame_done) begin
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_active   <= 1'b0;
    end else if (w_bit_end) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + 4'd1;
      r_shift    <= {r_shift[FRAME_LEN-2:0], 1'b1};
    end else if (r_active) begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Output stage after mtm_Alu_core: captures results and error reports and sends
// them as back-to-back 11-bit frames on sout.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ack,
  input  logic [31:0] result,
  input  logic [3:0]  flags,
  input  logic [2:0]  crc,
  input  logic        err_valid,
  input  logic [5:0]  err_flags,
  output logic        sout,
  output logic        busy
);

  // Handshake: res_valid is a level held by the core until served; a capture
  // happens only in IDLE while armed, and res_ack pulses for exactly one cycle
  // after it. armed stays low until res_valid drops, so the core's trailing
  // ack cycle cannot trigger a second capture.

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_frame_cnt, w_frame_cnt_nxt;
  logic        r_is_err, w_is_err_nxt;
  logic [31:0] r_result;
  logic [3:0]  r_flags;
  logic [2:0]  r_crc;
  logic        r_pend_err, w_pend_err_nxt;
  logic [5:0]  r_pend_flags, w_pend_flags_nxt;
  logic        r_pend_data, w_pend_data_nxt;
  logic        r_armed, w_armed_nxt;
  logic        r_res_ack, w_res_ack_nxt;
  logic        w_capture;
  logic        w_load;
  logic        w_load_type;
  logic [7:0]  w_load_byte;
  logic        w_frame_done;

  function automatic logic [7:0] data_byte(input logic [2:0] idx, input logic [31:0] res,
                                           input logic [3:0] fl, input logic [2:0] cr);
    case (idx)
      3'd0:    return res[31:24];
      3'd1:    return res[23:16];
      3'd2:    return res[15:8];
      3'd3:    return res[7:0];
      default: return {1'b0, fl, cr};
    endcase
  endfunction

  always_comb begin
    w_state_nxt      = r_state;
    w_frame_cnt_nxt  = r_frame_cnt;
    w_is_err_nxt     = r_is_err;
    w_pend_err_nxt   = r_pend_err;
    w_pend_flags_nxt = r_pend_flags;
    w_pend_data_nxt  = r_pend_data;
    w_armed_nxt      = res_valid ? r_armed : 1'b1;
    w_res_ack_nxt    = 1'b0;
    w_capture        = 1'b0;
    w_load           = 1'b0;
    w_load_type      = TYPE_DATA;
    w_load_byte      = '0;
    case (r_state)
      ST_IDLE: begin
        if (res_valid && r_armed) begin
          w_capture     = 1'b1;
          w_res_ack_nxt = 1'b1;
          w_armed_nxt   = 1'b0;
        end
        // An error report wins the line; a result captured alongside it is queued.
        if (err_valid) begin
          w_load          = 1'b1;
          w_load_type     = TYPE_CTL;
          w_load_byte     = ctl_err_byte(err_flags);
          w_is_err_nxt    = 1'b1;
          w_pend_data_nxt = w_capture;
          w_state_nxt     = ST_SEND;
        end else if (w_capture) begin
          w_load          = 1'b1;
          w_load_byte     = result[31:24];
          w_is_err_nxt    = 1'b0;
          w_frame_cnt_nxt = '0;
          w_state_nxt     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (err_valid) begin
          w_pend_err_nxt   = 1'b1;
          w_pend_flags_nxt = err_flags;
        end
        if (w_frame_done) begin
          if (!r_is_err && (r_frame_cnt != 3'(DATA_FRAMES))) begin
            w_load          = 1'b1;
            w_frame_cnt_nxt = r_frame_cnt + 3'd1;
            w_load_type     = (r_frame_cnt == 3'(DATA_FRAMES - 1)) ? TYPE_CTL : TYPE_DATA;
            w_load_byte     = data_byte(r_frame_cnt + 3'd1, r_result, r_flags, r_crc);
          end else if (r_pend_data) begin
            w_load          = 1'b1;
            w_load_byte     = r_result[31:24];
            w_frame_cnt_nxt = '0;
            w_is_err_nxt    = 1'b0;
            w_pend_data_nxt = 1'b0;
          end else if (w_pend_err_nxt) begin
            w_load         = 1'b1;
            w_load_type    = TYPE_CTL;
            w_load_byte    = ctl_err_byte(w_pend_flags_nxt);
            w_is_err_nxt   = 1'b1;
            w_pend_err_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_frame_cnt  <= '0;
      r_is_err     <= 1'b0;
      r_result     <= '0;
      r_flags      <= '0;
      r_crc        <= '0;
      r_pend_err   <= 1'b0;
      r_pend_flags <= '0;
      r_pend_data  <= 1'b0;
      r_armed      <= 1'b1;
      r_res_ack    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_is_err     <= w_is_err_nxt;
      r_pend_err   <= w_pend_err_nxt;
      r_pend_flags <= w_pend_flags_nxt;
      r_pend_data  <= w_pend_data_nxt;
      r_armed      <= w_armed_nxt;
      r_res_ack    <= w_res_ack_nxt;
      if (w_capture) begin
        r_result <= result;
        r_flags  <= flags;
        r_crc    <= crc;
      end
    end
  end

  mtm_alu_frame_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_frame_tx (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .i_load       (w_load),
    .i_type       (w_load_type),
    .i_byte       (w_load_byte),
    .o_sout       (sout),
    .o_frame_done (w_frame_done)
  );

  assign res_ack = r_res_ack;
  assign busy    = (r_state == ST_SEND);

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Bench for mtm_alu_serializer: two instances (1 and 4 clocks per bit) checked
// every cycle against a schedule of expected line bits built from the frame rules.
module tb_mtm_alu_serializer;

  localparam int MAXC = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  rst_v;
  logic [1:0]  res_valid_v;
  logic [1:0]  err_valid_v;
  logic [31:0] result_v    [2];
  logic [3:0]  flags_v     [2];
  logic [2:0]  crc_v       [2];
  logic [5:0]  err_flags_v [2];
  wire  [1:0]  sout_v;
  wire  [1:0]  busy_v;
  wire  [1:0]  ack_v;

  mtm_alu_serializer #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst_v[0]), .res_valid(res_valid_v[0]), .res_ack(ack_v[0]),
    .result(result_v[0]), .flags(flags_v[0]), .crc(crc_v[0]),
    .err_valid(err_valid_v[0]), .err_flags(err_flags_v[0]),
    .sout(sout_v[0]), .busy(busy_v[0])
  );

  mtm_alu_serializer #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst_v[1]), .res_valid(res_valid_v[1]), .res_ack(ack_v[1]),
    .result(result_v[1]), .flags(flags_v[1]), .crc(crc_v[1]),
    .err_valid(err_valid_v[1]), .err_flags(err_flags_v[1]),
    .sout(sout_v[1]), .busy(busy_v[1])
  );

  // ---------------- model: per-cycle line schedule ----------------
  bit exp_b [0:1][0:MAXC-1];   // line busy with a scheduled bit
  bit exp_s [0:1][0:MAXC-1];   // scheduled bit value
  bit exp_a [0:1][0:MAXC-1];   // res_ack expected
  int tx_end [2];              // first cycle the line is free again

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic int cpb(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [10:0] mk_frame(logic typ, logic [7:0] b);
    return {1'b0, typ, b, 1'b1};
  endfunction

  function automatic void put_frame(int d, logic [10:0] fr);
    for (int i = 10; i >= 0; i--) begin
      for (int r = 0; r < cpb(d); r++) begin
        if (tx_end[d] < MAXC) begin
          exp_b[d][tx_end[d]] = 1'b1;
          exp_s[d][tx_end[d]] = fr[i];
        end
        tx_end[d]++;
      end
    end
  endfunction

  function automatic void put_data(int d, logic [31:0] r, logic [3:0] f, logic [2:0] c);
    for (int k = 3; k >= 0; k--) put_frame(d, mk_frame(1'b0, r[k*8 +: 8]));
    put_frame(d, mk_frame(1'b1, {1'b0, f, c}));
  endfunction

  function automatic void put_err(int d, logic [5:0] ef);
    put_frame(d, mk_frame(1'b1, {1'b1, ef, ^{1'b1, ef}}));
  endfunction

  function automatic void clear_from(int d, int c);
    for (int i = c; i < MAXC; i++) begin
      exp_b[d][i] = 1'b0;
      exp_a[d][i] = 1'b0;
    end
    tx_end[d] = c;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string name, int d, logic got, logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %b expected %b", name, d, cyc, got, exp);
    end
  endtask

  task automatic chk_int(string name, longint got, longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      for (int d = 0; d < 2; d++) begin
        chk("sout", d, sout_v[d], exp_b[d][cyc] ? exp_s[d][cyc] : 1'b1);
        chk("busy", d, busy_v[d], exp_b[d][cyc]);
        chk("res_ack", d, ack_v[d], exp_a[d][cyc]);
      end
    end
  end

  // Observed counters and a recorder of the bits dut1 put on the line while busy.
  int          busy_cnt [2];
  int          ack_cnt  [2];
  logic [63:0] rec0;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (busy_v[d]) busy_cnt[d]++;
      if (ack_v[d])  ack_cnt[d]++;
    end
    if (busy_v[0]) rec0 = {rec0[62:0], sout_v[0]};
  end

  // ---------------- drivers ----------------
  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_res(int d, logic [31:0] r, logic [3:0] f, logic [2:0] c, int hold);
    int req;
    @(posedge clk); #2;
    result_v[d] = r; flags_v[d] = f; crc_v[d] = c;
    res_valid_v[d] = 1'b1;
    req = cyc + 1;
    if (tx_end[d] <= req) begin
      exp_a[d][req] = 1'b1;
      tx_end[d] = req;
      put_data(d, r, f, c);
    end
    repeat (hold + 1) begin @(posedge clk); #2; end
    res_valid_v[d] = 1'b0;
  endtask

  task automatic pulse_err(int d, logic [5:0] ef);
    int req;
    @(posedge clk); #2;
    err_flags_v[d] = ef;
    err_valid_v[d] = 1'b1;
    req = cyc + 1;
    if (tx_end[d] < req) tx_end[d] = req;
    put_err(d, ef);
    @(posedge clk); #2;
    err_valid_v[d] = 1'b0;
  endtask

  task automatic send_both(int d, logic [31:0] r, logic [3:0] f, logic [2:0] c, logic [5:0] ef);
    int req;
    @(posedge clk); #2;
    result_v[d] = r; flags_v[d] = f; crc_v[d] = c;
    err_flags_v[d] = ef;
    res_valid_v[d] = 1'b1;
    err_valid_v[d] = 1'b1;
    req = cyc + 1;
    if (tx_end[d] < req) tx_end[d] = req;
    exp_a[d][req] = 1'b1;
    put_err(d, ef);
    put_data(d, r, f, c);
    @(posedge clk); #2;
    err_valid_v[d] = 1'b0;
    @(posedge clk); #2;
    res_valid_v[d] = 1'b0;
  endtask

  task automatic pulse_rst(int d);
    @(posedge clk); #2;
    rst_v[d] = 1'b0;
    clear_from(d, cyc);
    #1;
    chk("rst_sout", d, sout_v[d], 1'b1);
    chk("rst_busy", d, busy_v[d], 1'b0);
    wait_cyc(2);
    rst_v[d] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_v = 2'b00; res_valid_v = 2'b00; err_valid_v = 2'b00;
    for (int d = 0; d < 2; d++) begin
      result_v[d] = '0; flags_v[d] = '0; crc_v[d] = '0; err_flags_v[d] = '0;
      tx_end[d] = 0; busy_cnt[d] = 0; ack_cnt[d] = 0;
    end
    rec0 = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_sout", d, sout_v[d], 1'b1);
      chk("reset_busy", d, busy_v[d], 1'b0);
      chk("reset_ack", d, ack_v[d], 1'b0);
    end
    repeat (3) @(posedge clk);
    #2;
    rst_v = 2'b11;

    // Data response with hand-computed frames
    busy_cnt[0] = 0; ack_cnt[0] = 0;
    send_res(0, 32'h12345678, 4'b0000, 3'b101, 1);
    wait_cyc(60);
    chk_int("t1_busy_cycles", busy_cnt[0], 55);
    chk_int("t1_ack_pulses", ack_cnt[0], 1);
    chk_int("t1_frame0", rec0[54:44], 11'b00000100101);
    chk_int("t1_frame1", rec0[43:33], 11'b00001101001);
    chk_int("t1_frame2", rec0[32:22], 11'b00010101101);
    chk_int("t1_frame3", rec0[21:11], 11'b00011110001);
    chk_int("t1_frame4", rec0[10:0],  11'b01000001011);

    // Error frame from IDLE
    busy_cnt[0] = 0;
    pulse_err(0, 6'b001001);
    wait_cyc(15);
    chk_int("t2_busy_cycles", busy_cnt[0], 11);
    chk_int("t2_err_frame", rec0[10:0], 11'b01100100111);

    // res_valid lingering after the ack must not re-capture
    ack_cnt[0] = 0;
    send_res(0, 32'hA5C30F96, 4'b1010, 3'b011, 3);
    wait_cyc(60);
    chk_int("t3_ack_pulses", ack_cnt[0], 1);

    // Error reported during the third data frame follows the CTL frame directly
    busy_cnt[0] = 0;
    send_res(0, 32'h87654321, 4'b1100, 3'b001, 1);
    wait_cyc(20);
    pulse_err(0, 6'b100110);
    wait_cyc(60);
    chk_int("t4_busy_cycles", busy_cnt[0], 66);

    // Reset in the middle of frame 2, then a clean response
    send_res(0, 32'hDEADBEEF, 4'b0011, 3'b100, 1);
    wait_cyc(14);
    pulse_rst(0);
    wait_cyc(3);
    busy_cnt[0] = 0;
    send_res(0, 32'h0F1E2D3C, 4'b0110, 3'b010, 1);
    wait_cyc(60);
    chk_int("t5_busy_cycles", busy_cnt[0], 55);

    // Simultaneous error and result: error frame first, then the data
    busy_cnt[0] = 0; ack_cnt[0] = 0;
    send_both(0, 32'h00FF00FF, 4'b1111, 3'b111, 6'b110100);
    wait_cyc(75);
    chk_int("both_busy_cycles", busy_cnt[0], 66);
    chk_int("both_ack_pulses", ack_cnt[0], 1);

    // Extra patterns
    send_res(0, 32'h00000000, 4'b1001, 3'b000, 1);
    wait_cyc(58);
    pulse_err(0, 6'b111111);
    wait_cyc(12);
    pulse_err(0, 6'b000000);
    wait_cyc(12);

    // Four clocks per bit
    busy_cnt[1] = 0;
    send_res(1, 32'hFFFFFFFF, 4'b0101, 3'b110, 1);
    wait_cyc(230);
    chk_int("t6_busy_cycles", busy_cnt[1], 220);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
